// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// Sizes of the 32x32 register file, the $zero index, FSM states and the
// write request bundle used inside the arbiter.
package regfile_pkg;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;

  // Architecturally hard-wired zero register; writes to it are swallowed.
  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_ARB   = 1'b1
  } wr_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// 2-way round-robin arbiter: combinational one-hot grant, pointer flop.
// Latency: grant in the same cycle as the request; pointer updates at the edge.
// Backpressure: en=0 forces gnt=0; the pointer only moves on contested grants.
module rr_arbiter2 (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // Priority pointer: 0 favours requester 0, 1 favours requester 1.
  logic       r_ptr;
  logic [1:0] w_req;

  assign w_req = en ? req : 2'b00;

  // Grant decode: a lone requester always wins, a tie goes to the pointer side.
  always_comb begin
    gnt = 2'b00;
    case (w_req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = r_ptr ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  // Pointer flips only when both sides competed, so uncontested grants keep fairness state.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_ptr <= 1'b0;
    end else if (w_req == 2'b11) begin
      r_ptr <= ~r_ptr;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Owns the register-file write port: zero-fills all registers after reset,
// then round-robins two writeback requesters. Latency: accepted request on WR_* next cycle.
// Backpressure: READYx is the accept strobe; none accepted during reset or the zero-fill.
module regfile_write_arbiter #(
  parameter int NUM_REGS       = regfile_pkg::NUM_REGS,
  parameter int ADDR_W         = regfile_pkg::ADDR_W,
  parameter int DATA_W         = regfile_pkg::DATA_W,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ0,
  input  logic [ADDR_W-1:0] ADDR0,
  input  logic [DATA_W-1:0] DATA0,
  output logic              READY0,
  input  logic              REQ1,
  input  logic [ADDR_W-1:0] ADDR1,
  input  logic [DATA_W-1:0] DATA1,
  output logic              READY1,
  output logic              WR_EN,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [DATA_W-1:0] WR_DATA,
  output logic              BUSY
);

  import regfile_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  wr_state_t         r_state;
  wr_state_t         w_state_nxt;
  logic [ADDR_W-1:0] r_count;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;

  logic              w_arb_en;
  logic [1:0]        w_gnt;
  logic              w_xfer;
  wr_req_t           w_sel;

  // State register; CLEAR_ON_RESET=0 skips straight to arbitration.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= CLEAR_ON_RESET ? S_CLEAR : S_ARB;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and arbitration enable; reset overrides everything so no request is taken.
  always_comb begin
    w_state_nxt = r_state;
    w_arb_en    = 1'b0;
    case (r_state)
      S_CLEAR: begin
        if (r_count == LAST_IDX) begin
          w_state_nxt = S_ARB;
        end
      end
      S_ARB: begin
        w_arb_en = ~RESET;
      end
      default: begin
        w_state_nxt = S_ARB;
      end
    endcase
  end

  rr_arbiter2 u_rr_arbiter2 (
    .CLK   (CLK),
    .RESET (RESET),
    .en    (w_arb_en),
    .req   ({REQ1, REQ0}),
    .gnt   (w_gnt)
  );

  assign w_xfer = |w_gnt;

  // Winner's payload; grant is one-hot, so bit 1 alone selects the source.
  always_comb begin
    w_sel.addr = w_gnt[1] ? ADDR1 : ADDR0;
    w_sel.data = w_gnt[1] ? DATA1 : DATA0;
  end

  // Registered write port. Zero-fill emits one write per cycle; in arbitration a
  // transfer to $zero is consumed but issues no write, leaving the bus unchanged.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_count   <= '0;
    end else if (r_state == S_CLEAR) begin
      r_wr_en   <= 1'b1;
      r_wr_addr <= r_count;
      r_wr_data <= '0;
      r_count   <= r_count + ADDR_W'(1);
    end else if (w_xfer && (w_sel.addr != ZERO_REG)) begin
      r_wr_en   <= 1'b1;
      r_wr_addr <= w_sel.addr;
      r_wr_data <= w_sel.data;
    end else begin
      r_wr_en   <= 1'b0;
    end
  end

  assign READY0  = w_gnt[0];
  assign READY1  = w_gnt[1];
  assign BUSY    = (r_state == S_CLEAR);
  assign WR_EN   = r_wr_en;
  assign WR_ADDR = r_wr_addr;
  assign WR_DATA = r_wr_data;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios plus
// randomized requesters, checked each cycle against a cycle-count based model.
// A second instance with CLEAR_ON_RESET=0 checks the no-clear start.
module tb_regfile_write_arbiter;

  localparam int NR = 32;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          REQ0, REQ1;
  logic [AW-1:0] ADDR0, ADDR1;
  logic [DW-1:0] DATA0, DATA1;
  logic          READY0, READY1, WR_EN, BUSY;
  logic [AW-1:0] WR_ADDR;
  logic [DW-1:0] WR_DATA;

  logic          b_ready0, b_ready1, b_wr_en, b_busy;
  logic [AW-1:0] b_wr_addr;
  logic [DW-1:0] b_wr_data;

  always #5 CLK = ~CLK;

  regfile_write_arbiter #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .CLEAR_ON_RESET(1'b1)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ0(REQ0), .ADDR0(ADDR0), .DATA0(DATA0), .READY0(READY0),
    .REQ1(REQ1), .ADDR1(ADDR1), .DATA1(DATA1), .READY1(READY1),
    .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .BUSY(BUSY)
  );

  regfile_write_arbiter #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .CLEAR_ON_RESET(1'b0)) dut_nc (
    .CLK(CLK), .RESET(RESET),
    .REQ0(REQ0), .ADDR0(ADDR0), .DATA0(DATA0), .READY0(b_ready0),
    .REQ1(REQ1), .ADDR1(ADDR1), .DATA1(DATA1), .READY1(b_ready1),
    .WR_EN(b_wr_en), .WR_ADDR(b_wr_addr), .WR_DATA(b_wr_data), .BUSY(b_busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state for the clearing instance.
  int            cyc      = 0;     // cycles since reset release
  bit            ptr      = 1'b0;  // whose turn on a tie
  int            m_gnt    = -1;    // grant issued in the last stepped cycle
  bit            wr_known = 1'b0;
  bit            amb      = 1'b0;  // last accept went to $zero: bus contents unspecified
  logic          exp_en   = 1'b0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_data = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: check outputs mid-cycle, then advance the model across the edge.
  task automatic step();
    int g;
    bit busy;
    g    = -1;
    busy = 1'b0;
    @(negedge CLK);
    if (RESET) begin
      chk("rst_ready0", READY0, 0);
      chk("rst_ready1", READY1, 0);
    end else begin
      busy = (cyc < NR);
      chk("busy", BUSY, busy);
      if (!busy) begin
        if (REQ0 && REQ1) begin
          g   = ptr ? 1 : 0;
          ptr = ~ptr;
        end else if (REQ0) begin
          g = 0;
        end else if (REQ1) begin
          g = 1;
        end
      end
      chk("ready0", READY0, g == 0);
      chk("ready1", READY1, g == 1);
    end
    if (wr_known) begin
      chk("wr_en", WR_EN, exp_en);
      if (exp_en || !amb) begin
        chk("wr_addr", WR_ADDR, exp_addr);
        chk("wr_data", WR_DATA, exp_data);
      end
    end
    @(posedge CLK);
    if (RESET) begin
      cyc = 0; ptr = 1'b0; wr_known = 1'b1; amb = 1'b0;
      exp_en = 1'b0; exp_addr = '0; exp_data = '0;
    end else if (busy) begin
      exp_en = 1'b1; exp_addr = AW'(cyc); exp_data = '0; amb = 1'b0;
      cyc++;
    end else begin
      if (g >= 0) begin
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        a = (g == 1) ? ADDR1 : ADDR0;
        d = (g == 1) ? DATA1 : DATA0;
        if (a != 0) begin
          exp_en = 1'b1; exp_addr = a; exp_data = d; amb = 1'b0;
        end else begin
          exp_en = 1'b0; amb = 1'b1;
        end
      end else begin
        exp_en = 1'b0;
      end
      if (cyc < 1000) cyc++;
    end
    m_gnt = g;
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    step();
    RESET = 1'b0;
  endtask

  initial begin
    int acc_cyc;
    int order;
    RESET = 1'b1;
    REQ0 = 1'b0; REQ1 = 1'b0;
    ADDR0 = '0; ADDR1 = '0; DATA0 = '0; DATA1 = '0;
    @(posedge CLK); #1;
    do_reset();
    chk("reset_wr_en", WR_EN, 0);
    chk("reset_wr_addr", WR_ADDR, 0);
    chk("reset_wr_data", WR_DATA, 0);

    // Request held through the zero-fill: accepted exactly at cycle 32.
    REQ0 = 1'b1; ADDR0 = 5; DATA0 = 32'hDEADBEEF;
    acc_cyc = -1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (m_gnt == 0) begin
        acc_cyc = i;
        REQ0 = 1'b0;
        break;
      end
    end
    chk("accept_cycle", acc_cyc, 32);
    step();
    chk("first_wr_addr", WR_ADDR, 5);

    // Both requesting: grants alternate starting from requester 0.
    REQ0 = 1'b1; ADDR0 = 3; DATA0 = 32'h33;
    REQ1 = 1'b1; ADDR1 = 7; DATA1 = 32'h77;
    order = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      order = order * 10 + m_gnt;
    end
    chk("rr_order", order, 101);
    REQ0 = 1'b0; REQ1 = 1'b0;
    step();

    // $zero write: consumed but no write issued.
    REQ1 = 1'b1; ADDR1 = 0; DATA1 = 32'hFFFFFFFF;
    step();
    chk("zero_accept", m_gnt, 1);
    REQ1 = 1'b0;
    step();

    // Reset in the middle of the zero-fill restarts it from register 0.
    do_reset();
    for (int i = 0; i < 10; i++) step();
    chk("mid_clear_addr", WR_ADDR, 9);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    for (int i = 0; i < 34; i++) step();

    // Randomized requesters honouring hold-until-accepted, with rare resets.
    for (int i = 0; i < 400; i++) begin
      if (m_gnt == 0 || !REQ0) begin
        REQ0 = ($urandom_range(1, 0) == 1);
        ADDR0 = ($urandom_range(7, 0) == 0) ? AW'(0) : AW'($urandom);
        DATA0 = $urandom;
      end else if ($urandom_range(7, 0) == 0) begin
        REQ0 = 1'b0;
      end
      if (m_gnt == 1 || !REQ1) begin
        REQ1 = ($urandom_range(1, 0) == 1);
        ADDR1 = ($urandom_range(7, 0) == 0) ? AW'(0) : AW'($urandom);
        DATA1 = $urandom;
      end else if ($urandom_range(7, 0) == 0) begin
        REQ1 = 1'b0;
      end
      RESET = ($urandom_range(99, 0) == 0);
      step();
    end
    RESET = 1'b0;

    // No-clear instance: request in the first cycle after reset goes straight through.
    REQ0 = 1'b0; REQ1 = 1'b0;
    do_reset();
    REQ1 = 1'b1; ADDR1 = 9; DATA1 = 32'h12345678;
    #1;
    chk("nc_busy", b_busy, 0);
    chk("nc_ready1", b_ready1, 1);
    chk("nc_ready0", b_ready0, 0);
    step();
    REQ1 = 1'b0;
    chk("nc_wr_en", b_wr_en, 1);
    chk("nc_wr_addr", b_wr_addr, 9);
    chk("nc_wr_data", b_wr_data, 32'h12345678);
    step();
    chk("nc_wr_en_idle", b_wr_en, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
